// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register chain (EX/MEM bundle layout).
// Honours PIPE_SKID_EN: when defined, occupancy widens to cover the skid entry.
package pipe_pkg;

  localparam int EXMEM_CTRL_W = 10;
  localparam int EXMEM_DATA_W = 165;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_SLTI     = 5;
  localparam int CTRL_JAL      = 6;
  localparam int CTRL_SHIFT    = 7;
  localparam int CTRL_MFHI     = 8;
  localparam int CTRL_MFLO     = 9;

  // EX/MEM data bundle layout, LSB first
  localparam int DATA_ZERO_LSB   = 0;
  localparam int DATA_BTGT_LSB   = 1;
  localparam int DATA_ALUOUT_LSB = 33;
  localparam int DATA_RD2_LSB    = 65;
  localparam int DATA_WN_LSB     = 97;
  localparam int DATA_PCINCR_LSB = 102;
  localparam int DATA_AUX_LSB    = 134;
  localparam int DATA_AUX_W      = 31;

  function automatic int occ_width(input int stages);
`ifdef PIPE_SKID_EN
    return $clog2(stages + 2);
`else
    return $clog2(stages + 1);
`endif
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid bit, valid-masked control bundle and data bundle.
// Flush clears valid/ctrl and leaves data as-is.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              up_valid,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (load) begin
      valid_reg <= up_valid;
      // a bubble carries all-zero control so it can never write memory or registers
      ctrl_reg  <= up_ctrl & {CTRL_W{up_valid}};
      data_reg  <= up_data;
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// STAGES-deep valid/ready pipeline register chain with flush-to-bubble.
// PIPE_SKID_EN adds a one-entry skid buffer in front of slot 0 with registered in_ready.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [DATA_W-1:0]            out_data,
  output logic [occ_width(STAGES)-1:0] occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] slot_valid;
  logic [CTRL_W-1:0] slot_ctrl [STAGES];
  logic [DATA_W-1:0] slot_data [STAGES];
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [OCC_W-1:0]  occ_sum;

  // slot i may load when some slot at or after it has a hole, or downstream drains
  assign adv[STAGES] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign adv[gi] = out_ready | ~(&slot_valid[STAGES-1:gi]);
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      logic              up_valid;
      logic [CTRL_W-1:0] up_ctrl;
      logic [DATA_W-1:0] up_data;

      if (gi == 0) begin : g_head
        assign up_valid = head_valid;
        assign up_ctrl  = head_ctrl;
        assign up_data  = head_data;
      end else begin : g_link
        assign up_valid = slot_valid[gi-1];
        assign up_ctrl  = slot_ctrl[gi-1];
        assign up_data  = slot_data[gi-1];
      end

      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .load     (adv[gi]),
        .up_valid (up_valid),
        .up_ctrl  (up_ctrl),
        .up_data  (up_data),
        .valid    (slot_valid[gi]),
        .ctrl     (slot_ctrl[gi]),
        .data     (slot_data[gi])
      );
    end
  endgenerate

`ifdef PIPE_SKID_EN
  logic              skid_valid_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;

  assign in_ready   = ~skid_valid_reg;
  // a parked entry is older than anything upstream, so it drains first
  assign head_valid = skid_valid_reg | in_valid;
  assign head_ctrl  = skid_valid_reg ? skid_ctrl_reg : in_ctrl;
  assign head_data  = skid_valid_reg ? skid_data_reg : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      skid_valid_reg <= 1'b0;
    end else if (adv[0]) begin
      skid_valid_reg <= 1'b0;
    end else if (in_valid && !skid_valid_reg) begin
      skid_valid_reg <= 1'b1;
      skid_ctrl_reg  <= in_ctrl;
      skid_data_reg  <= in_data;
    end
  end
`else
  assign in_ready   = adv[0];
  assign head_valid = in_valid;
  assign head_ctrl  = in_ctrl;
  assign head_data  = in_data;
`endif

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(slot_valid[i]);
    end
`ifdef PIPE_SKID_EN
    occ_sum = occ_sum + OCC_W'(skid_valid_reg);
`endif
  end

  assign occupancy = occ_sum;
  assign out_valid = slot_valid[STAGES-1];
  assign out_ctrl  = slot_ctrl[STAGES-1] & {CTRL_W{slot_valid[STAGES-1]}};
  assign out_data  = slot_data[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: table-driven STAGES=2 vectors plus hand sequences
// for async reset mid-stall and STAGES=1 stall/skid behaviour (PIPE_SKID_EN aware).
module tb_pipe_stage_chain;

`ifdef PIPE_SKID_EN
  localparam int OCC2_W = 2;
  localparam int OCC1_W = 2;
  localparam bit SKID   = 1'b1;
`else
  localparam int OCC2_W = 2;
  localparam int OCC1_W = 1;
  localparam bit SKID   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [9:0]        in_ctrl, out_ctrl;
  logic [164:0]      in_data, out_data;
  logic [OCC2_W-1:0] occupancy;

  logic              in_valid1, in_ready1, flush1, out_valid1, out_ready1;
  logic [9:0]        in_ctrl1, out_ctrl1;
  logic [164:0]      in_data1, out_data1;
  logic [OCC1_W-1:0] occupancy1;

  always #5 clk = ~clk;

  pipe_stage_chain #(.CTRL_W(10), .DATA_W(165), .STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_chain #(.CTRL_W(10), .DATA_W(165), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .flush(flush1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [9:0] ictrl;
    logic [7:0] idata;
    logic       ordy;
    logic       fl;
    logic       rdy;
    logic       ov;
    logic [9:0] octrl;
    logic [7:0] odata;
    logic       dchk;
    int         occ;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           iv    ictrl   idata  ordy  fl    rdy   ov    octrl   odata  dchk occ
    vecs[0]  = '{1'b1, 10'h008, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 1};
    vecs[1]  = '{1'b1, 10'h008, 8'hA6, 1'b1, 1'b0, 1'b1, 1'b1, 10'h008, 8'hA5, 1'b1, 2};
    vecs[2]  = '{1'b1, 10'h008, 8'hA7, 1'b1, 1'b0, 1'b1, 1'b1, 10'h008, 8'hA6, 1'b1, 2};
    vecs[3]  = '{1'b0, 10'h3FF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 10'h008, 8'hA7, 1'b1, 1};
    vecs[4]  = '{1'b0, 10'h3FF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'hFF, 1'b1, 0};
    vecs[5]  = '{1'b0, 10'h3FF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'hFF, 1'b1, 0};
    vecs[6]  = '{1'b0, 10'h3FF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'hFF, 1'b1, 0};
    vecs[7]  = '{1'b1, 10'h018, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 8'hFF, 1'b1, 1};
    vecs[8]  = '{1'b1, 10'h019, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 10'h018, 8'h11, 1'b1, 2};
    vecs[9]  = '{1'b1, 10'h01A, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 10'h018, 8'h11, 1'b1, 2};
    vecs[10] = '{1'b1, 10'h01A, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 10'h018, 8'h11, 1'b1, 2};
    vecs[11] = '{1'b1, 10'h01A, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 10'h018, 8'h11, 1'b1, 2};
    vecs[12] = '{1'b1, 10'h01A, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 10'h019, 8'h12, 1'b1, 2};
    vecs[13] = '{1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h01A, 8'h13, 1'b1, 1};
    vecs[14] = '{1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 0};
    vecs[15] = '{1'b1, 10'h3FF, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 1};
    vecs[16] = '{1'b1, 10'h3FF, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 10'h3FF, 8'h21, 1'b1, 2};
    vecs[17] = '{1'b1, 10'h3FF, 8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 0};
    vecs[18] = '{1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b0, 0};
    vecs[19] = '{1'b0, 10'h3FF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 0};

    rst = 1'b1;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_ctrl1 = '0; in_data1 = '0; flush1 = 1'b0; out_ready1 = 1'b0;

    // reset state, including out_ready=0 on the STAGES=1 instance
    #12;
    chk("rst.out_valid", 168'(out_valid), 168'd0);
    chk("rst.out_ctrl", 168'(out_ctrl), 168'd0);
    chk("rst.out_data", 168'(out_data), 168'd0);
    chk("rst.occupancy", 168'(occupancy), 168'd0);
    chk("rst.in_ready", 168'(in_ready), 168'd1);
    chk("rst.in_ready1", 168'(in_ready1), 168'd1);
    $display("reset: out_valid=%0b occ=%0d in_ready=%0b", out_valid, occupancy, in_ready);
    @(negedge clk);
    rst = 1'b0;
    out_ready1 = 1'b1;

`ifndef PIPE_SKID_EN
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ictrl;
      in_data   = {157'd0, vecs[i].idata};
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 168'(in_ready), 168'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", i), 168'(out_valid), 168'(vecs[i].ov));
      chk($sformatf("vec%0d.out_ctrl", i), 168'(out_ctrl), 168'(vecs[i].octrl));
      chk($sformatf("vec%0d.occupancy", i), 168'(occupancy), 168'(vecs[i].occ));
      if (vecs[i].dchk)
        chk($sformatf("vec%0d.out_data", i), 168'(out_data), 168'(vecs[i].odata));
      $display("vec %0d: iv=%0b ctrl=%h data=%h ordy=%0b fl=%0b -> rdy=%0b ov=%0b octrl=%h odata=%h occ=%0d",
               i, vecs[i].iv, vecs[i].ictrl, vecs[i].idata, vecs[i].ordy, vecs[i].fl,
               in_ready, out_valid, out_ctrl, out_data[7:0], occupancy);
    end

    // async reset while full and stalled
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 10'h008; in_data = 165'h51; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_data = 165'h52;
    @(negedge clk);
    in_data = 165'h53;
    #1;
    chk("stall.occupancy", 168'(occupancy), 168'd2);
    chk("stall.in_ready", 168'(in_ready), 168'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst.out_valid", 168'(out_valid), 168'd0);
    chk("arst.out_ctrl", 168'(out_ctrl), 168'd0);
    chk("arst.out_data", 168'(out_data), 168'd0);
    chk("arst.occupancy", 168'(occupancy), 168'd0);
    chk("arst.in_ready", 168'(in_ready), 168'd1);
    $display("async reset mid-stall: out_valid=%0b occ=%0d", out_valid, occupancy);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 165'h54; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.occupancy", 168'(occupancy), 168'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.out_valid", 168'(out_valid), 168'd1);
    chk("post_rst.out_data", 168'(out_data), 168'h54);
    chk("post_rst.out_ctrl", 168'(out_ctrl), 168'h008);
    $display("post-reset accept: out_valid=%0b out_data=%h", out_valid, out_data[7:0]);
`endif

    // STAGES=1: one-cycle latency, then a push against a stalled full slot
    @(negedge clk);
    in_valid1 = 1'b1; in_ctrl1 = 10'h008; in_data1 = 165'h41; out_ready1 = 1'b1;
    #1 chk("s1a.in_ready", 168'(in_ready1), 168'd1);
    @(posedge clk);
    #1;
    chk("s1a.out_valid", 168'(out_valid1), 168'd1);
    chk("s1a.out_ctrl", 168'(out_ctrl1), 168'h008);
    chk("s1a.out_data", 168'(out_data1), 168'h41);
    chk("s1a.occupancy", 168'(occupancy1), 168'd1);
    $display("s1 push 41: ov=%0b data=%h occ=%0d", out_valid1, out_data1[7:0], occupancy1);

    @(negedge clk);
    in_valid1 = 1'b1; in_ctrl1 = 10'h00A; in_data1 = 165'h42; out_ready1 = 1'b0;
    #1 chk("s1b.in_ready", 168'(in_ready1), 168'(SKID));
    @(posedge clk);
    #1;
    chk("s1b.out_valid", 168'(out_valid1), 168'd1);
    chk("s1b.out_data", 168'(out_data1), 168'h41);
    chk("s1b.occupancy", 168'(occupancy1), SKID ? 168'd2 : 168'd1);
    chk("s1b.in_ready_after", 168'(in_ready1), 168'd0);
    $display("s1 push 42 stalled: ov=%0b data=%h occ=%0d rdy=%0b",
             out_valid1, out_data1[7:0], occupancy1, in_ready1);

    @(negedge clk);
    out_ready1 = 1'b1;
`ifdef PIPE_SKID_EN
    in_valid1 = 1'b0; in_ctrl1 = 10'h3FF; in_data1 = 165'hEE;
    #1 chk("s1c.in_ready", 168'(in_ready1), 168'd0);
`else
    #1 chk("s1c.in_ready", 168'(in_ready1), 168'd1);
`endif
    @(posedge clk);
    #1;
    chk("s1c.out_valid", 168'(out_valid1), 168'd1);
    chk("s1c.out_ctrl", 168'(out_ctrl1), 168'h00A);
    chk("s1c.out_data", 168'(out_data1), 168'h42);
    chk("s1c.occupancy", 168'(occupancy1), 168'd1);
    chk("s1c.in_ready_after", 168'(in_ready1), 168'd1);
    $display("s1 drain: ov=%0b data=%h occ=%0d", out_valid1, out_data1[7:0], occupancy1);

    @(negedge clk);
    in_valid1 = 1'b0; in_ctrl1 = 10'h3FF;
    @(posedge clk);
    #1;
    chk("s1d.out_valid", 168'(out_valid1), 168'd0);
    chk("s1d.out_ctrl", 168'(out_ctrl1), 168'd0);
    chk("s1d.occupancy", 168'(occupancy1), 168'd0);
    $display("s1 empty: ov=%0b ctrl=%h occ=%0d", out_valid1, out_ctrl1, occupancy1);

`ifdef PIPE_SKID_EN
    // flush must also drop a parked skid entry
    @(negedge clk);
    in_valid1 = 1'b1; in_ctrl1 = 10'h001; in_data1 = 165'h61; out_ready1 = 1'b0;
    @(negedge clk);
    in_data1 = 165'h62;
    @(negedge clk);
    in_valid1 = 1'b0; flush1 = 1'b1;
    #1 chk("skflush.occ_before", 168'(occupancy1), 168'd2);
    @(posedge clk);
    #1;
    chk("skflush.occupancy", 168'(occupancy1), 168'd0);
    chk("skflush.in_ready", 168'(in_ready1), 168'd1);
    chk("skflush.out_valid", 168'(out_valid1), 168'd0);
    $display("skid flush: occ=%0d rdy=%0b", occupancy1, in_ready1);
    @(negedge clk);
    flush1 = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
